// File: rtl/ifetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// The request is held until the memory returns an ack with the instruction word.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Two-state instruction fetch unit: fetches the word at pc and presents its decoded fields.
// Fields are held while stalled; the PC then advances, or takes a branch on branch && zero.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ifetch_unit_if.master        imem,
  input  logic                 stall,
  input  logic                 branch,
  input  logic                 zero,
  output logic [5:0]           op,
  output logic [5:0]           func,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [15:0]          imm,
  output logic                 inst_valid,
  output logic [31:0]          pc_out
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_ir;
  logic [31:0] w_ir_nxt;
  logic [31:0] w_offset;
  logic [31:0] w_next_pc;

  // Branch offset is a word offset, so the sign-extended immediate is scaled by 4.
  assign w_offset  = (branch && zero) ? {{14{r_ir[15]}}, r_ir[15:0], 2'b00} : 32'h0000_0000;
  assign w_next_pc = r_pc + 32'd4 + w_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    imem.imem_req = 1'b0;
    inst_valid    = 1'b0;
    unique case (r_state)
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          w_ir_nxt    = imem.imem_rdata;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        inst_valid = 1'b1;
        if (!stall) begin
          w_pc_nxt    = w_next_pc;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  assign imem.imem_addr = r_pc;
  assign pc_out         = r_pc;
  assign op             = r_ir[31:26];
  assign rs             = r_ir[25:21];
  assign rt             = r_ir[20:16];
  assign rd             = r_ir[15:11];
  assign imm            = r_ir[15:0];
  assign func           = r_ir[5:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, fetch latency, stalls, branches, PC wrap and mid-fetch reset.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic        zero;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        inst_valid;
  logic [31:0] pc_out;

  int assertCount;
  int failCount;

  ifetch_unit_if imemBus ();

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imemBus.master),
    .stall      (stall),
    .branch     (branch),
    .zero       (zero),
    .op         (op),
    .func       (func),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .inst_valid (inst_valid),
    .pc_out     (pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  // Called at a negedge while in FETCH; waits waitCycles with no ack, then acks with word.
  task automatic applyStimulus(input logic [31:0] expPc, input logic [31:0] word, input int waitCycles);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < waitCycles; i++) begin
      imemBus.imem_ack   = 1'b0;
      imemBus.imem_rdata = 32'hDEAD_BEEF;
      checkOutput("wait_req", {31'b0, imemBus.imem_req}, 32'd1);
      checkOutput("wait_addr", imemBus.imem_addr, expPc);
      checkOutput("wait_valid", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
    end
    checkOutput("fetch_req", {31'b0, imemBus.imem_req}, 32'd1);
    checkOutput("fetch_addr", imemBus.imem_addr, expPc);
    imemBus.imem_ack   = 1'b1;
    imemBus.imem_rdata = w;
    @(negedge clk);
    imemBus.imem_ack   = 1'b0;
    imemBus.imem_rdata = 32'hDEAD_BEEF;
    checkOutput("issue_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("issue_req", {31'b0, imemBus.imem_req}, 32'd0);
    checkOutput("issue_pc", pc_out, expPc);
    checkOutput("issue_imm", {16'b0, imm}, {16'b0, w[15:0]});
    checkOutput("issue_op", {26'b0, op}, {26'b0, w[31:26]});
  endtask

  // Called at a negedge while in ISSUE; stalls with noise on branch/zero/ack, then releases.
  task automatic issueStep(input logic [31:0] curPc, input logic br, input logic zr,
                           input int stallCycles, input logic [31:0] nextPc);
    logic [15:0] heldImm;
    heldImm = imm;
    for (int i = 0; i < stallCycles; i++) begin
      stall              = 1'b1;
      branch             = 1'b1;
      zero               = 1'b1;
      imemBus.imem_ack   = 1'b1;
      imemBus.imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checkOutput("stall_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("stall_req", {31'b0, imemBus.imem_req}, 32'd0);
      checkOutput("stall_pc", pc_out, curPc);
      checkOutput("stall_imm", {16'b0, imm}, {16'b0, heldImm});
    end
    stall              = 1'b0;
    imemBus.imem_ack   = 1'b0;
    imemBus.imem_rdata = 32'hDEAD_BEEF;
    branch             = br;
    zero               = zr;
    @(negedge clk);
    branch = 1'b0;
    zero   = 1'b0;
    checkOutput("next_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("next_addr", imemBus.imem_addr, nextPc);
  endtask

  initial begin
    assertCount        = 0;
    failCount          = 0;
    rst_n              = 1'b0;
    stall              = 1'b0;
    branch             = 1'b0;
    zero               = 1'b0;
    imemBus.imem_ack   = 1'b1;
    imemBus.imem_rdata = 32'hFFFF_FFFF;
    #3;
    checkOutput("rst_req", {31'b0, imemBus.imem_req}, 32'd1);
    checkOutput("rst_addr", imemBus.imem_addr, 32'h0);
    checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_op", {26'b0, op}, 32'd0);
    checkOutput("rst_imm", {16'b0, imm}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-cycle ack of an add at the reset PC
    applyStimulus(32'h0000_0000, 32'h0000_0020, 0);
    checkOutput("add_func", {26'b0, func}, 32'h0000_0020);
    checkOutput("add_op", {26'b0, op}, 32'h0);
    issueStep(32'h0000_0000, 1'b0, 1'b0, 0, 32'h0000_0004);

    // Three-cycle memory latency
    applyStimulus(32'h0000_0004, 32'h8C22_0004, 3);
    checkOutput("lw_rt", {27'b0, rt}, 32'd2);
    checkOutput("lw_rs", {27'b0, rs}, 32'd1);
    issueStep(32'h0000_0004, 1'b0, 1'b0, 0, 32'h0000_0008);

    // beq +3 taken at 8 after a 4-cycle stall with a spurious ack
    applyStimulus(32'h0000_0008, 32'h1022_0003, 1);
    issueStep(32'h0000_0008, 1'b1, 1'b1, 4, 32'h0000_0018);

    // beq -5 taken at 0x18 returns to 8
    applyStimulus(32'h0000_0018, 32'h1022_FFFB, 0);
    issueStep(32'h0000_0018, 1'b1, 1'b1, 0, 32'h0000_0008);

    // beq +3 at 8 not taken (zero=0)
    applyStimulus(32'h0000_0008, 32'h1022_0003, 0);
    issueStep(32'h0000_0008, 1'b1, 1'b0, 0, 32'h0000_000C);

    applyStimulus(32'h0000_000C, 32'h0123_4820, 0);
    checkOutput("add_rd", {27'b0, rd}, 32'd9);
    issueStep(32'h0000_000C, 1'b0, 1'b0, 0, 32'h0000_0010);

    // beq -1 taken at 16 refetches 16
    applyStimulus(32'h0000_0010, 32'h1022_FFFF, 0);
    issueStep(32'h0000_0010, 1'b1, 1'b1, 0, 32'h0000_0010);

    // beq -6 taken at 16 lands on 0xFFFF_FFFC
    applyStimulus(32'h0000_0010, 32'h1022_FFFA, 0);
    issueStep(32'h0000_0010, 1'b1, 1'b1, 0, 32'hFFFF_FFFC);

    // Sequential step from the top of the address space wraps to 0
    applyStimulus(32'hFFFF_FFFC, 32'h1022_0003, 0);
    issueStep(32'hFFFF_FFFC, 1'b1, 1'b0, 0, 32'h0000_0000);

    applyStimulus(32'h0000_0000, 32'h0000_0020, 0);
    issueStep(32'h0000_0000, 1'b0, 1'b0, 0, 32'h0000_0004);

    // Reset pulsed during a FETCH wait, with an ack coinciding with reset
    imemBus.imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("prerst_addr", imemBus.imem_addr, 32'h0000_0004);
    rst_n              = 1'b0;
    imemBus.imem_ack   = 1'b1;
    imemBus.imem_rdata = 32'hFFFF_FFFF;
    #1;
    checkOutput("midrst_addr", imemBus.imem_addr, 32'h0);
    checkOutput("midrst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("midrst_op", {26'b0, op}, 32'd0);
    @(negedge clk);
    checkOutput("midrst_imm", {16'b0, imm}, 32'd0);
    rst_n            = 1'b1;
    imemBus.imem_ack = 1'b0;
    @(negedge clk);
    checkOutput("postrst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("postrst_func", {26'b0, func}, 32'd0);
    applyStimulus(32'h0000_0000, 32'h0000_0022, 0);
    checkOutput("postrst_sub", {26'b0, func}, 32'h0000_0022);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
